core_sequencer: RTL and testbench
=================================

Name: core_sequencer

Overview:
- Multi-cycle fetch/decode/execute sequencer for the 9-bit ISA core.
- Owns the PC and the instruction register, and drives instruction-memory and data-memory request handshakes.
- Consumes the control flags produced by the instruction decoder from the latched instruction. Gates register-file writes and PC update to one commit cycle per instruction.
- Sits between the memories and the register file/ALU at core top level.

Parameters:
- PC_W, 10, program counter width; PC wraps modulo 2^PC_W.
- INSTR_W, 9, instruction width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin execution from PC 0; sampled only in IDLE/HALT
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (= pc)
- imem_ack  in  1  fetch data valid this cycle
- imem_rdata  in  INSTR_W  fetched instruction
- ir  out  INSTR_W  latched instruction, drives the decoder
- dec_branch_en, dec_write_en, dec_mem_read, dec_mem_write, dec_done  in  1 each  decoder flags for ir
- branch_taken  in  1  ALU branch condition
- branch_target  in  PC_W  branch destination
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write strobe (valid with dmem_req)
- dmem_ack  in  1  data access complete
- reg_we  out  1  register-file write enable, single-cycle pulse
- pc  out  PC_W  current program counter
- busy  out  1  high in every state except IDLE/HALT
- done  out  1  high while in HALT

Behaviour:
- Reset (async, immediate): state=IDLE, pc=0, ir=0, all request/strobe outputs and done=0. Reset mid-handshake drops req immediately; no completion is owed.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: start=1 -> FETCH, pc=0.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack at an edge: ir<=imem_rdata, -> DECODE. Stays in FETCH indefinitely until ack.
- DECODE: one cycle for the combinational decoder to settle on ir; -> EXEC.
- EXEC, evaluated in priority order:
  - dec_done -> HALT (pc unchanged).
  - dec_mem_read|dec_mem_write -> MEM.
  - otherwise -> WB.
- MEM: dmem_req=1, dmem_we=dec_mem_write. Held stable until dmem_ack sampled; then -> WB. An ack arriving outside MEM is ignored.
- WB: reg_we=dec_write_en for exactly this cycle. pc<=(dec_branch_en&&branch_taken)?branch_target:pc+1 (wraps 2^PC_W-1 -> 0). Then -> FETCH.
- Minimum latency per instruction: FETCH(1 with immediate ack)+DECODE+EXEC+WB = 4 cycles; memory ops add at least 1.
- HALT: done=1, busy=0. start=1 -> pc=0, done=0, -> FETCH. start in any other state is ignored.
- Outputs imem_req, dmem_req, dmem_we, reg_we, done, busy are decoded from the registered state; none depend combinationally on acks.

Optional Feature:
CORE_SEQ_PERF_EN
- With the macro: adds outputs cycle_count[31:0] and instr_count[31:0].
  - cycle_count increments each cycle busy=1.
  - instr_count increments on each WB and on entry to HALT.
  - Both clear on reset and on start; both saturate at 2^32-1.
- Without the macro: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package core_pkg: state enum seq_state_t, PC_W/INSTR_W defaults, HALT_INSTR constant 9'b010000000.
- One natural sub-module: core_perf_counters, holding the saturating counters; instantiated only under CORE_SEQ_PERF_EN.

Test Plan:
- Reset then start, imem_ack immediate, three ALU ops (dec_write_en=1) -> reg_we pulses on cycles 4, 8, 12 after FETCH entry; pc=3.
- Load with dmem_ack delayed 3 cycles -> dmem_req held 3 cycles with dmem_we=0; a single reg_we follows in WB.
- Branch at pc=5, branch_taken=1, target=2 -> pc=2. Same with branch_taken=0 -> pc=6.
- pc=1023 non-branch -> pc wraps to 0.
- Halt instruction -> done=1, busy=0, no reg_we. start pulse -> pc=0, FETCH, done=0.
- rst_n low during MEM with dmem_req=1 -> dmem_req, pc and ir drop to 0 asynchronously; state IDLE; late dmem_ack ignored.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the 9-bit ISA core.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package core_pkg;

    // Default widths for the core datapath.
    localparam int PC_W_DEF    = 10;
    localparam int INSTR_W_DEF = 9;

    // Encoding the decoder recognises as the halt instruction.
    localparam logic [INSTR_W_DEF-1:0] HALT_INSTR = 9'b010000000;

    // Sequencer control states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } seq_state_t;

    // The core is busy in every state except the two parked states.
    function automatic logic state_is_busy(input seq_state_t s);
        return !((s == ST_IDLE) || (s == ST_HALT));
    endfunction

endpackage

// File: rtl/core_perf_counters.sv
// Saturating cycle and retired-instruction counters for the sequencer.
// Latency: counts visible one cycle after the qualifying event.
// Backpressure: none; counters hold at all-ones instead of wrapping.
module core_perf_counters (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_cyc_inc,
    input  logic        i_instr_inc,
    output logic [31:0] o_cycle_count,
    output logic [31:0] o_instr_count
);

    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instr_cnt;

    // Cycle counter: clears on start, otherwise counts busy cycles up to saturation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt <= '0;
        end else if (i_clear) begin
            r_cycle_cnt <= '0;
        end else if (i_cyc_inc && (r_cycle_cnt != 32'hFFFF_FFFF)) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
    end

    // Instruction counter: clears on start, otherwise counts retirements up to saturation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_cnt <= '0;
        end else if (i_clear) begin
            r_instr_cnt <= '0;
        end else if (i_instr_inc && (r_instr_cnt != 32'hFFFF_FFFF)) begin
            r_instr_cnt <= r_instr_cnt + 32'd1;
        end
    end

    assign o_cycle_count = r_cycle_cnt;
    assign o_instr_count = r_instr_cnt;

endmodule

// File: rtl/core_sequencer.sv
// Fetch/decode/execute sequencer owning PC and IR; optional perf counters under CORE_SEQ_PERF_EN.
// Latency: 4 cycles per instruction with immediate fetch ack, plus at least 1 for memory ops.
// Backpressure: waits indefinitely in FETCH for imem_ack and in MEM for dmem_ack; requests held stable.
module core_sequencer
    import core_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ir,
    input  logic               dec_branch_en,
    input  logic               dec_write_en,
    input  logic               dec_mem_read,
    input  logic               dec_mem_write,
    input  logic               dec_done,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic               dmem_req,
    output logic               dmem_we,
    input  logic               dmem_ack,
    output logic               reg_we,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               done
`ifdef CORE_SEQ_PERF_EN
    ,
    output logic [31:0]        cycle_count,
    output logic [31:0]        instr_count
`endif
);

    seq_state_t         r_state;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_ir;

    logic [PC_W-1:0]    w_pc_next;
    logic               w_take_branch;

    // Only a taken branch redirects; everything else falls through with natural wrap.
    assign w_take_branch = dec_branch_en && branch_taken;
    assign w_pc_next     = w_take_branch ? branch_target : (r_pc + PC_W'(1));

    // Control FSM: owns state, PC and IR; PC only moves in WB or on a (re)start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_pc    <= '0;
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        r_ir    <= imem_rdata;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    // Give the external decoder a full cycle to settle on the new IR.
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (dec_done) begin
                        r_state <= ST_HALT;
                    end else if (dec_mem_read || dec_mem_write) begin
                        r_state <= ST_MEM;
                    end else begin
                        r_state <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        r_state <= ST_WB;
                    end
                end
                ST_WB: begin
                    r_pc    <= w_pc_next;
                    r_state <= ST_FETCH;
                end
                ST_HALT: begin
                    if (start) begin
                        r_pc    <= '0;
                        r_state <= ST_FETCH;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake and status outputs decode purely from the registered state so
    // no ack ever reaches an output combinationally.
    assign imem_req  = (r_state == ST_FETCH);
    assign imem_addr = r_pc;
    assign dmem_req  = (r_state == ST_MEM);
    assign dmem_we   = (r_state == ST_MEM) && dec_mem_write;
    assign reg_we    = (r_state == ST_WB) && dec_write_en;
    assign busy      = state_is_busy(r_state);
    assign done      = (r_state == ST_HALT);
    assign pc        = r_pc;
    assign ir        = r_ir;

`ifdef CORE_SEQ_PERF_EN
    logic w_start_accept;
    logic w_retire;

    // A start is only honoured from the parked states; it also restarts the counters.
    assign w_start_accept = start && ((r_state == ST_IDLE) || (r_state == ST_HALT));
    // Each writeback retires an instruction, as does the halt that ends the program.
    assign w_retire       = (r_state == ST_WB) || ((r_state == ST_EXEC) && dec_done);

    core_perf_counters u_perf (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_clear       (w_start_accept),
        .i_cyc_inc     (busy),
        .i_instr_inc   (w_retire),
        .o_cycle_count (cycle_count),
        .o_instr_count (instr_count)
    );
`endif

endmodule

// File: tb/tb_core_sequencer.sv
module tb_core_sequencer;
    import core_pkg::*;

    localparam int PW = 10;
    localparam int IW = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic          imem_ack;
    logic [IW-1:0] imem_rdata;
    logic [IW-1:0] ir;
    logic          dec_branch_en, dec_write_en, dec_mem_read, dec_mem_write, dec_done;
    logic          branch_taken;
    logic [PW-1:0] branch_target;
    logic          dmem_req, dmem_we, dmem_ack, reg_we;
    logic [PW-1:0] pc;
    logic          busy, done;
`ifdef CORE_SEQ_PERF_EN
    logic [31:0]   cycle_count, instr_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [PW-1:0] m_pc;   // reference program counter

    always #5 clk = ~clk;

    core_sequencer #(.PC_W(PW), .INSTR_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ir(ir),
        .dec_branch_en(dec_branch_en), .dec_write_en(dec_write_en), .dec_mem_read(dec_mem_read),
        .dec_mem_write(dec_mem_write), .dec_done(dec_done),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .reg_we(reg_we), .pc(pc), .busy(busy), .done(done)
`ifdef CORE_SEQ_PERF_EN
        , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
    );

    // Bench-side instruction decoder: 11=branch, 10=memory (bit6 store), else ALU (bit0 writes).
    typedef struct packed { logic br; logic we; logic rd; logic wr; logic dn; } flags_t;

    function automatic flags_t decode(input logic [IW-1:0] i);
        flags_t f;
        f = '0;
        if (i == HALT_INSTR) f.dn = 1'b1;
        else if (i[8:7] == 2'b11) f.br = 1'b1;
        else if (i[8:7] == 2'b10) begin
            if (i[6]) f.wr = 1'b1;
            else begin f.rd = 1'b1; f.we = 1'b1; end
        end else f.we = i[0];
        return f;
    endfunction

    flags_t w_flags;
    assign w_flags       = decode(ir);
    assign dec_branch_en = w_flags.br;
    assign dec_write_en  = w_flags.we;
    assign dec_mem_read  = w_flags.rd;
    assign dec_mem_write = w_flags.wr;
    assign dec_done      = w_flags.dn;

    function automatic logic [IW-1:0] mk_alu(input logic we);
        logic [5:0] r;
        r = 6'($urandom);
        return {2'b00, r, we};
    endfunction
    function automatic logic [IW-1:0] mk_load();
        logic [5:0] r;
        r = 6'($urandom);
        return {2'b10, 1'b0, r};
    endfunction
    function automatic logic [IW-1:0] mk_store();
        logic [5:0] r;
        r = 6'($urandom);
        return {2'b10, 1'b1, r};
    endfunction
    function automatic logic [IW-1:0] mk_br();
        logic [6:0] r;
        r = 7'($urandom);
        return {2'b11, r};
    endfunction

    // Runs one instruction from its first FETCH cycle, acting as both memories,
    // and checks timing, strobes and the architectural result against the model.
    task automatic exec_one(input string tag, input logic [IW-1:0] instr, input int iw, input int dw,
                            input logic take, input logic [PW-1:0] tgt, output int reg_we_pos);
        flags_t f;
        logic mem;
        int exp_len, exp_we;
        logic [PW-1:0] exp_pc;
        int cycles, fcnt, mcnt, wcnt, we_bad, addr_bad;
        logic left, timeout;
        f = decode(instr);
        mem = f.rd | f.wr;
        exp_len = iw + 2 + (mem ? dw : 0) + (f.dn ? 0 : 1);
        exp_we  = (f.we && !f.dn) ? 1 : 0;
        exp_pc  = f.dn ? m_pc : ((f.br && take) ? tgt : m_pc + 10'd1);
        cycles = 0; fcnt = 0; mcnt = 0; wcnt = 0; we_bad = 0; addr_bad = 0;
        left = 1'b0; timeout = 1'b1; reg_we_pos = 0;
        branch_taken = take; branch_target = tgt;
        for (int k = 0; k < 400; k++) begin
            if (done || (imem_req && left)) begin timeout = 1'b0; break; end
            cycles++;
            if (imem_req) begin
                if (imem_addr !== m_pc) addr_bad++;
                fcnt++;
                imem_ack = (fcnt == iw);
                imem_rdata = instr;
            end else begin
                left = 1'b1;
                imem_ack = 1'($urandom);
            end
            if (dmem_req) begin
                mcnt++;
                if (dmem_we !== f.wr) we_bad++;
                dmem_ack = (mcnt == dw);
            end else begin
                dmem_ack = 1'($urandom);   // stray acks outside MEM must be ignored
            end
            if (reg_we) begin wcnt++; reg_we_pos = cycles; end
            start = 1'(($urandom % 4) == 0);  // start while busy must be ignored
            @(negedge clk);
        end
        imem_ack = 1'b0; dmem_ack = 1'b0; start = 1'b0;
        n_tests++;
        if (timeout) begin n_fail++; $display("FAIL %s timeout: no completion within 400 cycles", tag); end
        n_tests++;
        if (cycles != exp_len) begin n_fail++; $display("FAIL %s latency: got %0d expected %0d", tag, cycles, exp_len); end
        n_tests++;
        if (pc !== exp_pc) begin n_fail++; $display("FAIL %s pc: got %0d expected %0d", tag, pc, exp_pc); end
        n_tests++;
        if (wcnt != exp_we) begin n_fail++; $display("FAIL %s reg_we pulses: got %0d expected %0d", tag, wcnt, exp_we); end
        n_tests++;
        if (mcnt != (mem ? dw : 0)) begin n_fail++; $display("FAIL %s dmem_req cycles: got %0d expected %0d", tag, mcnt, mem ? dw : 0); end
        n_tests++;
        if (we_bad != 0) begin n_fail++; $display("FAIL %s dmem_we: %0d bad cycles expected %0d", tag, we_bad, 0); end
        n_tests++;
        if (addr_bad != 0) begin n_fail++; $display("FAIL %s imem_addr: %0d bad cycles expected %0d", tag, addr_bad, 0); end
        n_tests++;
        if (ir !== instr) begin n_fail++; $display("FAIL %s ir: got %h expected %h", tag, ir, instr); end
        n_tests++;
        if (done !== f.dn || busy !== !f.dn) begin
            n_fail++; $display("FAIL %s done/busy: got %b/%b expected %b/%b", tag, done, busy, f.dn, !f.dn);
        end
        m_pc = exp_pc;
    endtask

    // Pulses start from IDLE/HALT and checks the restart into FETCH at pc 0.
    task automatic do_start(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_pc = '0;
        n_tests++;
        if (imem_req !== 1'b1 || done !== 1'b0 || pc !== 10'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s start: got req=%b done=%b pc=%0d busy=%b expected 1 0 0 1", tag, imem_req, done, pc, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({imem_req, dmem_req, dmem_we, reg_we, busy, done} !== 6'b0 || pc !== 10'd0 || ir !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ctl=%b pc=%0d ir=%h expected 0", {imem_req, dmem_req, dmem_we, reg_we, busy, done}, pc, ir);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++; $display("FAIL idle_hold: got busy=%b req=%b expected 0 0", busy, imem_req);
        end
        m_pc = '0;
    endtask

    task automatic test_alu();
        int pos;
        do_start("alu");
        for (int i = 0; i < 3; i++) begin
            exec_one("alu", mk_alu(1'b1), 1, 1, 1'b0, 10'd0, pos);
            n_tests++;
            if (pos + 4 * i != 4 * (i + 1)) begin
                n_fail++; $display("FAIL alu_we_cycle: got %0d expected %0d", pos + 4 * i, 4 * (i + 1));
            end
        end
        n_tests++;
        if (pc !== 10'd3) begin n_fail++; $display("FAIL alu_pc: got %0d expected 3", pc); end
`ifdef CORE_SEQ_PERF_EN
        n_tests++;
        if (cycle_count !== 32'd12 || instr_count !== 32'd3) begin
            n_fail++; $display("FAIL perf: got %0d/%0d expected 12/3", cycle_count, instr_count);
        end
`endif
    endtask

    task automatic test_load();
        int pos;
        exec_one("load", mk_load(), 1, 3, 1'b0, 10'd0, pos);
        exec_one("store", mk_store(), 2, 2, 1'b0, 10'd0, pos);
    endtask

    task automatic test_branch();
        int pos;
        exec_one("br_to5", mk_br(), 1, 1, 1'b1, 10'd5, pos);
        exec_one("br_taken", mk_br(), 1, 1, 1'b1, 10'd2, pos);
        n_tests++;
        if (pc !== 10'd2) begin n_fail++; $display("FAIL br_taken_pc: got %0d expected 2", pc); end
        exec_one("br_to5b", mk_br(), 1, 1, 1'b1, 10'd5, pos);
        exec_one("br_not", mk_br(), 1, 1, 1'b0, 10'd2, pos);
        n_tests++;
        if (pc !== 10'd6) begin n_fail++; $display("FAIL br_not_pc: got %0d expected 6", pc); end
    endtask

    task automatic test_wrap();
        int pos;
        exec_one("br_to1023", mk_br(), 1, 1, 1'b1, 10'd1023, pos);
        exec_one("wrap", mk_alu(1'b0), 1, 1, 1'b0, 10'd0, pos);
        n_tests++;
        if (pc !== 10'd0) begin n_fail++; $display("FAIL wrap_pc: got %0d expected 0", pc); end
    endtask

    task automatic test_halt();
        int pos;
        logic [PW-1:0] hpc;
        exec_one("pre_halt", mk_alu(1'b1), 1, 1, 1'b0, 10'd0, pos);
        hpc = m_pc;
        exec_one("halt", HALT_INSTR, 2, 1, 1'b0, 10'd0, pos);
        repeat (4) @(negedge clk);
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0 || pc !== hpc || reg_we !== 1'b0) begin
            n_fail++; $display("FAIL halt_hold: got done=%b busy=%b pc=%0d expected 1 0 %0d", done, busy, pc, hpc);
        end
        do_start("restart");
        exec_one("after_restart", mk_alu(1'b1), 1, 1, 1'b0, 10'd0, pos);
    endtask

    task automatic test_random();
        int pos, sel;
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3: exec_one("rnd_alu", mk_alu(1'($urandom)), $urandom_range(1, 3), 1, 1'b0, 10'd0, pos);
                4, 5:       exec_one("rnd_load", mk_load(), $urandom_range(1, 3), $urandom_range(1, 4), 1'b0, 10'd0, pos);
                6:          exec_one("rnd_store", mk_store(), $urandom_range(1, 3), $urandom_range(1, 4), 1'b0, 10'd0, pos);
                7, 8:       exec_one("rnd_br", mk_br(), $urandom_range(1, 3), 1, 1'($urandom), 10'($urandom), pos);
                default: begin
                    exec_one("rnd_halt", HALT_INSTR, $urandom_range(1, 3), 1, 1'b0, 10'd0, pos);
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    do_start("rnd_restart");
                end
            endcase
        end
    endtask

    task automatic test_reset_mid();
        int pos;
        logic saw_mem, saw_we;
        exec_one("mid_alu", mk_alu(1'b1), 1, 1, 1'b0, 10'd0, pos);
        imem_rdata = mk_load();
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        saw_mem = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (dmem_req) begin saw_mem = 1'b1; break; end
            @(negedge clk);
        end
        n_tests++;
        if (!saw_mem) begin n_fail++; $display("FAIL mid_reach_mem: got dmem_req=%b expected 1", dmem_req); end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (dmem_req !== 1'b0 || pc !== 10'd0 || ir !== 9'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_async: got req=%b pc=%0d ir=%h busy=%b expected 0 0 0 0", dmem_req, pc, ir, busy);
        end
        dmem_ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        saw_we = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (reg_we || busy || imem_req || dmem_req) saw_we = 1'b1;
        end
        dmem_ack = 1'b0;
        n_tests++;
        if (saw_we) begin n_fail++; $display("FAIL mid_late_ack: activity after reset got 1 expected 0"); end
        m_pc = '0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        dmem_ack = 1'b0; branch_taken = 1'b0; branch_target = '0; m_pc = '0;
        @(negedge clk);
        test_reset();
        test_alu();
        test_load();
        test_branch();
        test_wrap();
        test_halt();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
